uart_crypt_ctrl: RTL
====================

# uart_crypt_ctrl

Sequencing controller between the UART receiver, the byte-wide crypto stage (Caesar cipher or simple hash), and the UART transmitter. It buffers received bytes in a small FIFO and feeds them one at a time through the crypto stage. It launches each result on the transmitter and waits for that transmission to finish before sending the next. It also decodes an in-band escape sequence that reconfigures the cipher key (shift), so the key can be changed over the serial link at run time.

## Interface
Parameters:
- FIFO_DEPTH, 4: receive-buffer entries; power of two, ≥2.
- ESC, 8'h1B: escape byte; the next received byte becomes the key.
- KEY_RESET, 8'h01: key value after reset.
- TIMEOUT, 15: maximum cycles to wait for tx_busy to rise after tx_start.

Ports:
- clock  in  1  single system clock; everything is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  byte from the receiver.
- rx_valid  in  1  one-cycle pulse; rx_data is valid this cycle.
- crypt_in  out  8  byte presented to the crypto stage (combinational, equals the FIFO head).
- crypt_out  in  8  crypto-stage result for crypt_in; purely combinational, same cycle.
- key  out  8  current shift/key sent to the crypto stage.
- tx_data  out  8  registered byte for the transmitter.
- tx_start  out  1  one-cycle transmit request.
- tx_busy  in  1  high while the transmitter is shifting a frame.
- overflow  out  1  sticky flag: a data byte was dropped because the FIFO was full.
- timeout  out  1  sticky flag: tx_busy never rose within TIMEOUT cycles.

## Operation
- Reset values (asserted asynchronously): tx_data=0, tx_start=0, key=KEY_RESET, overflow=0, timeout=0, FIFO empty, esc_pending=0, state=IDLE, wait counter=0.
- Receive path, on an rx_valid cycle:
  - If esc_pending=0 and rx_data==ESC: set esc_pending; the byte is not queued.
  - If esc_pending=1: key<=rx_data and clear esc_pending; the byte is not queued. ESC,ESC therefore sets key=8'h1B.
  - Otherwise, queue rx_data. If the FIFO is full and no pop occurs this cycle, drop the byte and set overflow.
- Simultaneous push and pop when full: the push is accepted, the count is unchanged, and no overflow is flagged.
- FIFO:
  - Circular buffer with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo depth.
  - The count is one bit wider than the pointers.
  - crypt_in = mem[rd_ptr] at all times; the value is don't-care when the FIFO is empty.
- FSM states IDLE, START, WAIT_HI, WAIT_LO:
  - IDLE: if the FIFO is not empty, tx_data<=crypt_out, pop, go to START. Otherwise stay.
  - START: tx_start=1 for exactly this cycle; clear the counter; go to WAIT_HI.
  - WAIT_HI:
    - If tx_busy=1, go to WAIT_LO.
    - Else if counter==TIMEOUT-1, set timeout and go to IDLE.
    - Else counter+1.
  - WAIT_LO: when tx_busy=0, go to IDLE.
- The key is sampled through crypt_out at the IDLE pop. A key change affects only bytes popped after the key register updates, including bytes already queued.
- The escape decoder runs independently of the FSM; a key update never stalls transmission.

## Timing
- Receive latency: rx_valid at edge N writes the FIFO. IDLE sees it non-empty in cycle N+1, tx_data is valid after edge N+1, and tx_start is high in cycle N+2. Minimum latency is 2 cycles from rx_valid to tx_start.
- Back-to-back bytes: the next tx_start comes no earlier than 2 cycles after tx_busy falls (WAIT_LO→IDLE→START).
- tx_start is never high on two consecutive cycles. tx_data is stable from START until the next IDLE pop.
- A timeout abandons the byte; it is not retried.
- Asserting reset in any state returns all state to reset values immediately, including a FIFO that is mid-drain.

## Test plan
- Single byte 8'h41 with key=1 and a cipher-model crypt_out: tx_data=8'h42, tx_start pulses exactly once 2 cycles after rx_valid; the transmitter model returns busy for 10 cycles, then the FSM is back in IDLE.
- Escape: send 8'h1B, 8'h03, then 8'h41. Nothing is queued for the first two bytes, key=8'h03, and tx_data=8'h44. Then send 8'h1B, 8'h1B: key=8'h1B, and still nothing is transmitted.
- Overflow with FIFO_DEPTH=4 and busy held high: 6 bytes arrive 1..6. Bytes 1-5 are transmitted in order (byte 1 is popped before byte 6 arrives) and byte 6 is dropped; overflow=1 and stays set.
- Push and pop in the same cycle with the FIFO full: count stays 4, overflow stays 0, and the byte order is preserved across pointer wrap.
- Timeout: tx_busy tied low. After tx_start, exactly 15 cycles pass, then timeout=1 and the next queued byte's tx_start follows.
- Reset mid-drain: assert reset with 3 bytes queued in WAIT_LO. All outputs go to reset values immediately, no further tx_start occurs, and key=8'h01.

Source files
------------

// File: rtl/uart_crypt_ctrl.sv
// uart_crypt_ctrl: sequences received bytes through a byte-wide crypto stage
// into the UART transmitter. A small FIFO decouples the receiver from the
// transmitter, and an in-band escape byte reloads the cipher key at run time.
module uart_crypt_ctrl #(
   parameter int unsigned FIFO_DEPTH = 4,       // power of two, >= 2
   parameter logic [7:0]  ESC        = 8'h1B,   // next byte after this is the key
   parameter logic [7:0]  KEY_RESET  = 8'h01,
   parameter int unsigned TIMEOUT    = 15       // cycles allowed for tx_busy to rise
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [7:0] i_rx_data,
   input  logic       i_rx_valid,
   output logic [7:0] o_crypt_in,
   input  logic [7:0] i_crypt_out,
   output logic [7:0] o_key,
   output logic [7:0] o_tx_data,
   output logic       o_tx_start,
   input  logic       i_tx_busy,
   output logic       o_overflow,
   output logic       o_timeout
);

   localparam int unsigned PW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_WAIT_HI,
      S_WAIT_LO
   } state_t;

   state_t        r_state;
   state_t        w_next_state;
   logic [7:0]    r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [PW:0]   r_count;
   logic          r_esc_pending;
   logic [7:0]    r_key;
   logic [7:0]    r_tx_data;
   logic          r_overflow;
   logic          r_timeout;
   logic [CW-1:0] r_wait_cnt;

   logic          w_empty;
   logic          w_full;
   logic          w_is_data;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_timeout_hit;
   logic          w_tx_start;

   // FIFO status and the push/pop decisions for this cycle.
   assign w_empty       = (r_count == '0);
   assign w_full        = (r_count == (PW+1)'(FIFO_DEPTH));
   assign w_is_data     = i_rx_valid && !r_esc_pending && (i_rx_data != ESC);
   assign w_pop         = (r_state == S_IDLE) && !w_empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_push        = w_is_data && (!w_full || w_pop);
   assign w_drop        = w_is_data && w_full && !w_pop;
   assign w_timeout_hit = (r_state == S_WAIT_HI) && !i_tx_busy &&
                          (r_wait_cnt == CW'(TIMEOUT - 1));

   assign o_crypt_in = r_mem[r_rd_ptr];
   assign o_key      = r_key;
   assign o_tx_data  = r_tx_data;
   assign o_tx_start = w_tx_start;
   assign o_overflow = r_overflow;
   assign o_timeout  = r_timeout;

   // FIFO storage write port.
   // NOTE: the data array has no reset; pointers and count define emptiness,
   // so clearing the storage would only cost flops.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_rx_data;
   end

   // FIFO pointers and occupancy count; pointers wrap modulo the depth.
   // NOTE: non-blocking assignments keep every register sampling pre-edge values.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PW+1)'(1);
            2'b01:   r_count <= r_count - (PW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Escape decoder: ESC arms, the following byte becomes the key.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_esc_pending <= 1'b0;
         r_key         <= KEY_RESET;
      end else if (i_rx_valid) begin
         if (r_esc_pending) begin
            r_key         <= i_rx_data;
            r_esc_pending <= 1'b0;
         end else if (i_rx_data == ESC) begin
            r_esc_pending <= 1'b1;
         end
      end
   end

   // Sticky error flags.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_overflow <= 1'b0;
         r_timeout  <= 1'b0;
      end else begin
         if (w_drop)        r_overflow <= 1'b1;
         if (w_timeout_hit) r_timeout  <= 1'b1;
      end
   end

   // Transmit byte capture at the pop and the busy-rise wait counter.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_tx_data  <= '0;
         r_wait_cnt <= '0;
      end else begin
         if (w_pop) r_tx_data <= i_crypt_out;
         if (r_state == S_START)
            r_wait_cnt <= '0;
         else if ((r_state == S_WAIT_HI) && !i_tx_busy && !w_timeout_hit)
            r_wait_cnt <= r_wait_cnt + CW'(1);
      end
   end

   // FSM state register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_next_state;
   end

   // FSM next-state and transmit request decode.
   // NOTE: defaults first so every path assigns every output; no latches.
   always_comb begin
      w_next_state = r_state;
      w_tx_start   = 1'b0;
      case (r_state)
         S_IDLE:    if (!w_empty) w_next_state = S_START;
         S_START: begin
            w_tx_start   = 1'b1;
            w_next_state = S_WAIT_HI;
         end
         S_WAIT_HI: begin
            if (i_tx_busy)          w_next_state = S_WAIT_LO;
            else if (w_timeout_hit) w_next_state = S_IDLE;
         end
         S_WAIT_LO: if (!i_tx_busy) w_next_state = S_IDLE;
         default:   w_next_state = S_IDLE;
      endcase
   end

endmodule
